// File: rtl/imem_loader.sv
// Byte-wide programmable instruction memory that feeds the single-cycle processor.
// Switch-entered programs are loaded in LOAD mode and fetched combinationally in RUN mode.
module imem_loader #(
   parameter int unsigned ADDR_W = 5,
   parameter logic [7:0]  FILL   = 8'h00
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              mode,
   input  logic              wr_btn,
   input  logic [7:0]        din,
   input  logic [7:0]        pc,
   output logic [7:0]        inst,
   output logic              proc_clr,
   output logic [ADDR_W-1:0] load_addr,
   output logic [ADDR_W:0]   prog_len,
   output logic              full
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CMP_W = ((ADDR_W + 1) > 8) ? (ADDR_W + 1) : 8;

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] load_addr_q, load_addr_d;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic [7:0]        mem_q [DEPTH];

   logic              mode_m_q, mode_s_q;
   logic              wr_m_q, wr_s_q, wr_q;
   logic              wr_pulse;
   logic              wr_en;
   logic              full_w;
   logic [CMP_W-1:0]  pc_ext, len_ext;
   logic              fetch_hit;

   // Two-flop synchronizers plus one delay flop for press edge detection
   always_ff @(posedge clk) begin
      if (clr) begin
         mode_m_q <= 1'b0;
         mode_s_q <= 1'b0;
         wr_m_q   <= 1'b0;
         wr_s_q   <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         mode_m_q <= mode;
         mode_s_q <= mode_m_q;
         wr_m_q   <= wr_btn;
         wr_s_q   <= wr_m_q;
         wr_q     <= wr_s_q;
      end
   end

   assign wr_pulse = wr_s_q & ~wr_q;
   assign full_w   = (prog_len_q == (ADDR_W + 1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_LOAD;
         load_addr_q <= '0;
         prog_len_q  <= '0;
      end else begin
         state_q     <= state_d;
         load_addr_q <= load_addr_d;
         prog_len_q  <= prog_len_d;
      end
   end

   // A pending mode change takes precedence over a write pulse in the same cycle
   always_comb begin
      state_d     = state_q;
      load_addr_d = load_addr_q;
      prog_len_d  = prog_len_q;
      wr_en       = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (mode_s_q) begin
               state_d = S_RUN;
            end else if (wr_pulse && !full_w) begin
               wr_en       = 1'b1;
               load_addr_d = load_addr_q + ADDR_W'(1);
               prog_len_d  = prog_len_q + (ADDR_W + 1)'(1);
            end
         end
         S_RUN: begin
            if (!mode_s_q) begin
               state_d     = S_LOAD;
               load_addr_d = '0;
               prog_len_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         mem_q <= '{default: '0};
      end else if (wr_en) begin
         mem_q[load_addr_q] <= din;
      end
   end

   // Full 8-bit pc is compared so addresses at or beyond DEPTH fall back to FILL
   assign pc_ext    = CMP_W'(pc);
   assign len_ext   = CMP_W'(prog_len_q);
   assign fetch_hit = (state_q == S_RUN) && (pc_ext < len_ext);

   always_comb begin
      inst = FILL;
      if (fetch_hit) begin
         inst = mem_q[pc[ADDR_W-1:0]];
      end
   end

   assign proc_clr  = (state_q == S_LOAD);
   assign load_addr = load_addr_q;
   assign prog_len  = prog_len_q;
   assign full      = full_w;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loading, fetch, press edge handling, full, mode races, reset.
module tb_imem_loader;

   logic       clk;
   logic       clr;
   logic       mode;
   logic       wr_btn;
   logic [7:0] din;
   logic [7:0] pc;
   logic [7:0] inst;
   logic       proc_clr;
   logic [4:0] load_addr;
   logic [5:0] prog_len;
   logic       full;

   int unsigned total = 0;
   int unsigned bad   = 0;

   imem_loader #(
      .ADDR_W (5),
      .FILL   (8'h00)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .mode      (mode),
      .wr_btn    (wr_btn),
      .din       (din),
      .pc        (pc),
      .inst      (inst),
      .proc_clr  (proc_clr),
      .load_addr (load_addr),
      .prog_len  (prog_len),
      .full      (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic press(input logic [7:0] d, input int unsigned hold);
      din    = d;
      wr_btn = 1'b1;
      tick(hold);
      wr_btn = 1'b0;
      tick(3);
   endtask

   task automatic fetch(input string tag, input logic [7:0] addr, input logic [7:0] exp_v);
      pc = addr;
      #1;
      chk(tag, {24'h0, inst}, {24'h0, exp_v});
   endtask

   initial begin
      clr    = 1'b1;
      mode   = 1'b0;
      wr_btn = 1'b0;
      din    = 8'h00;
      pc     = 8'h00;
      tick(2);
      clr = 1'b0;
      #1;
      chk("rst_inst",      {24'h0, inst},     32'h00);
      chk("rst_proc_clr",  {31'h0, proc_clr}, 32'h1);
      chk("rst_load_addr", {27'h0, load_addr}, 32'h0);
      chk("rst_prog_len",  {26'h0, prog_len}, 32'h0);
      chk("rst_full",      {31'h0, full},     32'h0);

      // three-byte program
      press(8'h41, 1);
      chk("p1_len", {26'h0, prog_len}, 32'd1);
      press(8'h82, 1);
      press(8'hC3, 1);
      chk("p3_len",  {26'h0, prog_len},  32'd3);
      chk("p3_addr", {27'h0, load_addr}, 32'd3);
      fetch("load_inst_fill", 8'h00, 8'h00);

      mode = 1'b1;
      tick(1);
      chk("run_pc_e1", {31'h0, proc_clr}, 32'h1);
      tick(1);
      chk("run_pc_e2", {31'h0, proc_clr}, 32'h1);
      tick(1);
      chk("run_pc_e3", {31'h0, proc_clr}, 32'h0);
      chk("run_len",   {26'h0, prog_len}, 32'd3);
      fetch("fetch0",    8'h00, 8'h41);
      fetch("fetch1",    8'h01, 8'h82);
      fetch("fetch2",    8'h02, 8'hC3);
      fetch("fetch3",    8'h03, 8'h00);
      fetch("fetchFF",   8'hFF, 8'h00);

      // back to LOAD clears counters
      mode = 1'b0;
      tick(2);
      chk("load_back_e2", {31'h0, proc_clr}, 32'h0);
      tick(1);
      chk("load_back_pc",   {31'h0, proc_clr},  32'h1);
      chk("load_back_len",  {26'h0, prog_len},  32'd0);
      chk("load_back_addr", {27'h0, load_addr}, 32'd0);

      // long hold yields one write
      press(8'h55, 50);
      chk("hold_len",  {26'h0, prog_len},  32'd1);
      chk("hold_addr", {27'h0, load_addr}, 32'd1);

      // fill all 32 entries from a clean reset
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      for (int unsigned i = 0; i < 31; i++) press(8'(i), 1);
      chk("len31",  {26'h0, prog_len}, 32'd31);
      chk("full31", {31'h0, full},     32'h0);
      press(8'd31, 1);
      chk("len32",  {26'h0, prog_len},  32'd32);
      chk("full32", {31'h0, full},      32'h1);
      chk("addr32", {27'h0, load_addr}, 32'd0);
      press(8'hEE, 1);
      chk("ovf_len",  {26'h0, prog_len},  32'd32);
      chk("ovf_addr", {27'h0, load_addr}, 32'd0);
      chk("ovf_full", {31'h0, full},      32'h1);
      mode = 1'b1;
      tick(3);
      chk("full_run", {31'h0, proc_clr}, 32'h0);
      fetch("full_m0",  8'h00, 8'h00);
      fetch("full_m5",  8'h05, 8'h05);
      fetch("full_m31", 8'h1F, 8'h1F);
      fetch("full_m32", 8'h20, 8'h00);

      // write and mode rising together
      mode = 1'b0;
      tick(3);
      press(8'hAA, 1);
      chk("race_pre_len", {26'h0, prog_len}, 32'd1);
      din    = 8'hBB;
      wr_btn = 1'b1;
      mode   = 1'b1;
      tick(3);
      chk("race_run", {31'h0, proc_clr}, 32'h0);
      chk("race_len", {26'h0, prog_len}, 32'd1);
      wr_btn = 1'b0;
      tick(3);
      chk("race_len2", {26'h0, prog_len}, 32'd1);
      fetch("race_m0", 8'h00, 8'hAA);
      fetch("race_m1", 8'h01, 8'h00);

      // reset mid-load discards the partial program
      mode = 1'b0;
      tick(3);
      press(8'h11, 1);
      press(8'h22, 1);
      chk("mid_len", {26'h0, prog_len}, 32'd2);
      clr = 1'b1;
      tick(1);
      chk("mid_rst_pc",   {31'h0, proc_clr},  32'h1);
      chk("mid_rst_len",  {26'h0, prog_len},  32'd0);
      chk("mid_rst_addr", {27'h0, load_addr}, 32'd0);
      clr  = 1'b0;
      mode = 1'b1;
      tick(1);
      chk("mid_e1_pc", {31'h0, proc_clr}, 32'h1);
      tick(1);
      chk("mid_e2_pc", {31'h0, proc_clr}, 32'h1);
      tick(1);
      chk("mid_e3_pc",  {31'h0, proc_clr}, 32'h0);
      chk("mid_run_len", {26'h0, prog_len}, 32'd0);
      fetch("mid_m0", 8'h00, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
